// File: rtl/comp_serie_pkg.sv
/******************************************************************************
 * Module  : comp_serie_pkg
 * Brief   : FSM state codes and counter-width helper for the serial comparator.
 * Rev     : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

package comp_serie_pkg;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMP  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  // Bit counter must hold N-1 and stay at least one bit wide for N=1.
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/comp_serie_bit.sv
/******************************************************************************
 * Module  : comp_bit
 * Brief   : One-bit gate-level magnitude comparator cell.
 * Rev     : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module comp_bit (
  input  logic a,
  input  logic b,
  output logic M,
  output logic igual,
  output logic m
);

  assign M     = a & ~b;
  assign m     = ~a & b;
  assign igual = ~(M | m);

endmodule

`default_nettype wire

// File: rtl/comp_serie.sv
/******************************************************************************
 * Module  : comp_serie
 * Brief   : Bit-serial MSB-first unsigned comparator; early exit on first
 *           differing bit, registered M/igual/m flags and a done pulse.
 * Rev     : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module comp_serie
  import comp_serie_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         busy,
  output logic         done,
  output logic         M,
  output logic         igual,
  output logic         m
);

  localparam int CW = cnt_width(N);

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [N-1:0]  r_sa;
  logic [N-1:0]  r_sb;
  logic [CW-1:0] r_cnt;
  logic          r_gt;
  logic          r_eq;
  logic          r_lt;
  logic          w_gt;
  logic          w_eq;
  logic          w_lt;

  comp_bit u_comp_bit (
    .a     (r_sa[N-1]),
    .b     (r_sb[N-1]),
    .M     (w_gt),
    .igual (w_eq),
    .m     (w_lt)
  );

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE: w_next = start ? S_CMP : S_IDLE;
      S_CMP:  w_next = (!w_eq || r_cnt == '0) ? S_DONE : S_CMP;
      S_DONE: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_CMP);
    done = (r_state == S_DONE);
  end

  // Datapath: operand shifters, bit counter and sticky result flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sa  <= '0;
      r_sb  <= '0;
      r_cnt <= '0;
      r_gt  <= 1'b0;
      r_eq  <= 1'b0;
      r_lt  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_sa  <= a;
            r_sb  <= b;
            r_cnt <= CW'(N - 1);
            r_gt  <= 1'b0;
            r_eq  <= 1'b0;
            r_lt  <= 1'b0;
          end
        end
        S_CMP: begin
          if (w_gt) begin
            r_gt <= 1'b1;
          end else if (w_lt) begin
            r_lt <= 1'b1;
          end else if (w_eq && r_cnt == '0) begin
            r_eq <= 1'b1;
          end else begin
            r_sa  <= r_sa << 1;
            r_sb  <= r_sb << 1;
            r_cnt <= r_cnt - CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign M     = r_gt;
  assign igual = r_eq;
  assign m     = r_lt;

endmodule

`default_nettype wire

// File: tb/tb_comp_serie.sv
/******************************************************************************
 * Module  : tb_comp_serie
 * Brief   : Randomized self-checking bench for comp_serie (N=4 and N=1).
 * Rev     : 1.0 - initial release
 ******************************************************************************/
`default_nettype none

module tb_comp_serie;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start4 = 1'b0, start1 = 1'b0;
  logic [3:0] a4 = '0, b4 = '0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       busy4, done4, gt4, eq4, lt4;
  logic       busy1, done1, gt1, eq1, lt1;
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         sel1 = 1'b0;

  always #5 clk = ~clk;

  comp_serie #(.N(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .M(gt4), .igual(eq4), .m(lt4)
  );

  comp_serie #(.N(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1),
    .busy(busy1), .done(done1), .M(gt1), .igual(eq1), .m(lt1)
  );

  wire       w_busy  = sel1 ? busy1 : busy4;
  wire       w_done  = sel1 ? done1 : done4;
  wire [2:0] w_flags = sel1 ? {gt1, eq1, lt1} : {gt4, eq4, lt4};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Cycles spent in CMP: position (from MSB) of the first differing bit, or w.
  function automatic int ref_lat(input int av, input int bv, input int w);
    int x;
    x = av ^ bv;
    for (int i = w - 1; i >= 0; i--)
      if (x[i]) return w - i;
    return w;
  endfunction

  function automatic logic [2:0] ref_flags(input int av, input int bv);
    return {av > bv, av == bv, av < bv};
  endfunction

  task automatic drive(input logic s, input int av, input int bv);
    if (sel1) begin
      start1 = s; a1 = 1'(av); b1 = 1'(bv);
    end else begin
      start4 = s; a4 = 4'(av); b4 = 4'(bv);
    end
  endtask

  // One compare; noise=1 keeps hammering start with junk operands while busy/done.
  task automatic run_cmp(input int av, input int bv, input bit noise);
    int w, k;
    logic [2:0] exp;
    w   = sel1 ? 1 : 4;
    k   = ref_lat(av, bv, w);
    exp = ref_flags(av, bv);
    @(negedge clk) drive(1'b1, av, bv);
    @(posedge clk) #1;
    for (int c = 1; c <= k; c++) begin
      chk("busy_cmp", 32'(w_busy), 1);
      chk("done_cmp", 32'(w_done), 0);
      chk("flags_cmp", 32'(w_flags), 0);
      @(negedge clk) drive(noise & 1'($urandom), int'($urandom), int'($urandom));
      @(posedge clk) #1;
    end
    chk("done_pulse", 32'(w_done), 1);
    chk("busy_done", 32'(w_busy), 0);
    chk("flags_done", 32'(w_flags), 32'(exp));
    @(negedge clk) drive(noise, int'($urandom), int'($urandom));
    @(posedge clk) #1;
    chk("done_after", 32'(w_done), 0);
    chk("busy_after", 32'(w_busy), 0);
    chk("flags_hold", 32'(w_flags), 32'(exp));
    @(negedge clk) drive(1'b0, 0, 0);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 32'(busy4), 0);
    chk("rst_done", 32'(done4), 0);
    chk("rst_flags", 32'({gt4, eq4, lt4}), 0);
    chk("rst_flags1", 32'({busy1, done1, gt1, eq1, lt1}), 0);
    @(negedge clk) rst = 1'b0;

    // Directed cases, N=4
    run_cmp(4'b1010, 4'b1010, 1'b0);
    run_cmp(4'b1000, 4'b0111, 1'b0);
    run_cmp(4'b0011, 4'b0101, 1'b0);
    run_cmp(4'b0000, 4'b1111, 1'b1);
    run_cmp(4'b1111, 4'b0000, 1'b0);

    // Reset in the middle of a compare: abort, no done afterwards
    @(negedge clk) drive(1'b1, 4'b0001, 4'b0000);
    @(posedge clk);
    @(negedge clk) drive(1'b0, 0, 0);
    @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
    chk("abort_busy", 32'(busy4), 0);
    chk("abort_out", 32'({done4, gt4, eq4, lt4}), 0);
    @(negedge clk) rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk) #1;
      chk("abort_nodone", 32'({busy4, done4}), 0);
    end

    // Randomized, N=4
    for (int t = 0; t < 60; t++)
      run_cmp(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), 1'($urandom));

    // N=1 instance
    sel1 = 1'b1;
    run_cmp(1, 0, 1'b0);
    run_cmp(1, 1, 1'b0);
    run_cmp(0, 1, 1'b1);
    run_cmp(0, 0, 1'b1);
    for (int t = 0; t < 10; t++)
      run_cmp(int'($urandom_range(0, 1)), int'($urandom_range(0, 1)), 1'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
